// File: rtl/ma_pkg.sv
// Shared definitions for the memory-access stage controller.
//   - FSM state encoding
//   - result-select encodings driven on M_sel_result
//   - poison value returned for a timed-out load
//   - memory request payload
package ma_pkg;

   localparam int unsigned XLEN = 32;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      REQ      = 2'd1,
      WAIT_RSP = 2'd2,
      DONE     = 2'd3
   } ma_state_e;

   // Write-back mux selections
   localparam logic [1:0] SEL_ALU = 2'b00;
   localparam logic [1:0] SEL_MEM = 2'b01;
   localparam logic [1:0] SEL_PC4 = 2'b10;
   localparam logic [1:0] SEL_IMM = 2'b11;

   localparam logic [XLEN-1:0] POISON = 32'hDEADBEEF;

   typedef struct packed {
      logic            we;
      logic [XLEN-1:0] addr;
      logic [XLEN-1:0] wdata;
   } mem_req_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter.
//   clk, rst_n : clock, async active-low reset
//   en         : count this cycle
//   count      : current value, sticks at all-ones
module sat_counter #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (en && (count != '1)) begin
         count <= count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/ma_dmem_ctrl.sv
// Memory-access stage controller: turns the MA-stage load/store into a
// valid/ready data-memory transaction, stalls the pipeline while it is
// outstanding and registers load data for write-back.
//   M_*            : EX/MA pipeline register fields (address, store data, controls)
//   stall          : combinational pipeline freeze
//   M_rd_data      : registered load data (poison on timeout)
//   mem_req_*      : request channel to data memory
//   mem_rsp_*      : read response channel from data memory
//   err_misaligned : sticky misaligned-access flag
//   err_timeout    : sticky load-timeout flag
//   stall_cnt      : saturating count of stalled cycles
module ma_dmem_ctrl #(
   parameter int unsigned TIMEOUT = 16,
   parameter logic [1:0]  SEL_MEM = ma_pkg::SEL_MEM
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] M_alu_o,
   input  logic [31:0] M_dm_wd,
   input  logic        M_we_dm,
   input  logic        M_we_rf,
   input  logic [1:0]  M_sel_result,
   output logic        stall,
   output logic [31:0] M_rd_data,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic        mem_req_we,
   output logic [31:0] mem_req_addr,
   output logic [31:0] mem_req_wdata,
   input  logic        mem_rsp_valid,
   input  logic [31:0] mem_rsp_rdata,
   output logic        err_misaligned,
   output logic        err_timeout,
   output logic [31:0] stall_cnt
);

   import ma_pkg::*;

   localparam int unsigned TW = $clog2(TIMEOUT + 1);

   ma_state_e     state;
   ma_state_e     state_next;
   mem_req_t      req_q;
   logic [TW-1:0] tmo_cnt;
   logic          is_store;
   logic          is_load;
   logic          is_access;
   logic          aligned;
   logic          tmo_hit;

   // A store wins when both store and load are flagged
   assign is_store  = M_we_dm;
   assign is_load   = M_we_rf && (M_sel_result == SEL_MEM);
   assign is_access = is_store || is_load;
   assign aligned   = (M_alu_o[1:0] == 2'b00);

   // The increment that would bring the wait counter up to TIMEOUT
   assign tmo_hit = !mem_req_ready && (tmo_cnt == TW'(TIMEOUT - 1));

   assign mem_req_we    = req_q.we;
   assign mem_req_addr  = req_q.addr;
   assign mem_req_wdata = req_q.wdata;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next state and stall
   always_comb begin
      state_next = state;
      stall      = 1'b0;
      case (state)
         IDLE: begin
            if (is_access && aligned) begin
               state_next = REQ;
               stall      = 1'b1;
            end
         end
         REQ: begin
            stall = 1'b1;
            if (mem_req_ready) begin
               state_next = req_q.we ? DONE : WAIT_RSP;
            end
         end
         WAIT_RSP: begin
            stall = 1'b1;
            if (mem_rsp_valid || tmo_hit) begin
               state_next = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
      // The pipeline must not see a freeze while held in reset
      if (!rst_n) begin
         stall = 1'b0;
      end
   end

   // Request fields, load data, wait counter and error flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_q          <= '0;
         mem_req_valid  <= 1'b0;
         M_rd_data      <= '0;
         tmo_cnt        <= '0;
         err_misaligned <= 1'b0;
         err_timeout    <= 1'b0;
      end else begin
         mem_req_valid <= (state_next == REQ);
         case (state)
            IDLE: begin
               if (is_access) begin
                  if (aligned) begin
                     req_q.we    <= is_store;
                     req_q.addr  <= {M_alu_o[31:2], 2'b00};
                     req_q.wdata <= M_dm_wd;
                  end else begin
                     err_misaligned <= 1'b1;
                  end
               end
            end
            REQ: begin
               if (mem_req_ready) begin
                  tmo_cnt <= '0;
               end
            end
            WAIT_RSP: begin
               if (mem_rsp_valid) begin
                  M_rd_data <= mem_rsp_rdata;
               end else if (tmo_hit) begin
                  M_rd_data   <= POISON;
                  err_timeout <= 1'b1;
               end else if (!mem_req_ready) begin
                  tmo_cnt <= tmo_cnt + TW'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Stalled-cycle counter
   sat_counter #(
      .WIDTH(32)
   ) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (stall),
      .count (stall_cnt)
   );

endmodule

// File: tb/tb_ma_dmem_ctrl.sv
// Directed self-checking bench for ma_dmem_ctrl.
module tb_ma_dmem_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] M_alu_o = '0;
   logic [31:0] M_dm_wd = '0;
   logic        M_we_dm = 1'b0;
   logic        M_we_rf = 1'b0;
   logic [1:0]  M_sel_result = 2'b00;
   logic        stall;
   logic [31:0] M_rd_data;
   logic        mem_req_valid;
   logic        mem_req_ready = 1'b0;
   logic        mem_req_we;
   logic [31:0] mem_req_addr;
   logic [31:0] mem_req_wdata;
   logic        mem_rsp_valid = 1'b0;
   logic [31:0] mem_rsp_rdata = '0;
   logic        err_misaligned;
   logic        err_timeout;
   logic [31:0] stall_cnt;

   int checks = 0;
   int errors = 0;

   ma_dmem_ctrl #(
      .TIMEOUT (16),
      .SEL_MEM (2'b01)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .M_alu_o        (M_alu_o),
      .M_dm_wd        (M_dm_wd),
      .M_we_dm        (M_we_dm),
      .M_we_rf        (M_we_rf),
      .M_sel_result   (M_sel_result),
      .stall          (stall),
      .M_rd_data      (M_rd_data),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_req_we     (mem_req_we),
      .mem_req_addr   (mem_req_addr),
      .mem_req_wdata  (mem_req_wdata),
      .mem_rsp_valid  (mem_rsp_valid),
      .mem_rsp_rdata  (mem_rsp_rdata),
      .err_misaligned (err_misaligned),
      .err_timeout    (err_timeout),
      .stall_cnt      (stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic drive_nop();
      M_we_dm      = 1'b0;
      M_we_rf      = 1'b0;
      M_sel_result = 2'b00;
      M_alu_o      = '0;
      M_dm_wd      = '0;
   endtask

   // Issues one access and plays the memory side; returns once DONE is seen
   // (stall low after the first cycle), with inputs already back to a nop.
   task automatic run_access(input logic we_dm, input logic we_rf, input logic [1:0] sel,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input int ready_lat, input int rsp_lat, input logic [31:0] rdata,
                             input logic exp_we, output int ns, output int nr);
      bit accepted = 0;
      bit done = 0;
      int widx = 0;
      ns = 0;
      nr = 0;
      @(negedge clk);
      M_we_dm = we_dm; M_we_rf = we_rf; M_sel_result = sel; M_alu_o = addr; M_dm_wd = wd;
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
      #1;
      if (stall) ns++;
      for (int c = 0; c < 100 && !done; c++) begin
         if (mem_req_valid && mem_req_ready) accepted = 1;
         @(negedge clk);
         mem_rsp_valid = 1'b0;
         mem_rsp_rdata = '0;
         if (accepted) begin
            if (widx == rsp_lat) begin
               mem_rsp_valid = 1'b1;
               mem_rsp_rdata = rdata;
            end
            widx++;
         end
         mem_req_ready = 1'b0;
         if (mem_req_valid) begin
            nr++;
            mem_req_ready = (nr > ready_lat);
            checks++;
            if (mem_req_we !== exp_we || mem_req_addr !== addr || mem_req_wdata !== wd) begin
               errors++;
               $display("FAIL req_fields got we=%b addr=%h wd=%h exp we=%b addr=%h wd=%h",
                        mem_req_we, mem_req_addr, mem_req_wdata, exp_we, addr, wd);
            end
         end
         #1;
         if (stall) begin
            ns++;
         end else begin
            done = 1;
            drive_nop();
            mem_req_ready = 1'b0;
            mem_rsp_valid = 1'b0;
         end
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL access_done got no DONE within 100 cycles exp DONE");
      end
   endtask

   task automatic test_reset();
      drive_nop();
      M_we_rf = 1'b1; M_sel_result = 2'b01; M_alu_o = 32'h0000_0010;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (stall !== 1'b0 || mem_req_valid !== 1'b0 || mem_req_we !== 1'b0 ||
          mem_req_addr !== 32'h0 || mem_req_wdata !== 32'h0 || M_rd_data !== 32'h0 ||
          err_misaligned !== 1'b0 || err_timeout !== 1'b0 || stall_cnt !== 32'h0) begin
         errors++;
         $display("FAIL reset_state got stall=%b v=%b we=%b a=%h wd=%h rd=%h em=%b et=%b sc=%0d exp all zero",
                  stall, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, M_rd_data,
                  err_misaligned, err_timeout, stall_cnt);
      end
      drive_nop();
      rst_n = 1'b1;
   endtask

   task automatic test_store();
      int ns, nr;
      run_access(1'b1, 1'b0, 2'b00, 32'h100, 32'hCAFEF00D, 0, -1, 32'h0, 1'b1, ns, nr);
      checks++;
      if (ns != 2 || nr != 1) begin
         errors++;
         $display("FAIL store_latency got stall=%0d req=%0d exp stall=2 req=1", ns, nr);
      end
      checks++;
      if (stall_cnt !== 32'd2 || mem_req_valid !== 1'b0) begin
         errors++;
         $display("FAIL store_done got stall_cnt=%0d valid=%b exp 2 0", stall_cnt, mem_req_valid);
      end
   endtask

   task automatic test_load();
      int ns, nr;
      run_access(1'b0, 1'b1, 2'b01, 32'h200, 32'h0, 0, 0, 32'h12345678, 1'b0, ns, nr);
      checks++;
      if (ns != 3 || nr != 1) begin
         errors++;
         $display("FAIL load_latency got stall=%0d req=%0d exp stall=3 req=1", ns, nr);
      end
      checks++;
      if (M_rd_data !== 32'h12345678 || stall_cnt !== 32'd5) begin
         errors++;
         $display("FAIL load_data got rd=%h sc=%0d exp 12345678 5", M_rd_data, stall_cnt);
      end
   endtask

   task automatic test_store_wait();
      int ns, nr;
      run_access(1'b1, 1'b0, 2'b00, 32'h104, 32'h0BADCAFE, 5, -1, 32'h0, 1'b1, ns, nr);
      checks++;
      if (ns != 7 || nr != 6) begin
         errors++;
         $display("FAIL store_wait got stall=%0d req=%0d exp stall=7 req=6", ns, nr);
      end
      checks++;
      if (M_rd_data !== 32'h12345678 || stall_cnt !== 32'd12) begin
         errors++;
         $display("FAIL store_wait_hold got rd=%h sc=%0d exp 12345678 12", M_rd_data, stall_cnt);
      end
   endtask

   task automatic test_timeout();
      int ns, nr;
      run_access(1'b0, 1'b1, 2'b01, 32'h208, 32'h0, 0, -1, 32'h0, 1'b0, ns, nr);
      checks++;
      if (ns != 18 || nr != 1) begin
         errors++;
         $display("FAIL timeout_latency got stall=%0d req=%0d exp stall=18 req=1", ns, nr);
      end
      checks++;
      if (M_rd_data !== 32'hDEADBEEF || err_timeout !== 1'b1 || err_misaligned !== 1'b0 ||
          stall_cnt !== 32'd30) begin
         errors++;
         $display("FAIL timeout_result got rd=%h et=%b em=%b sc=%0d exp deadbeef 1 0 30",
                  M_rd_data, err_timeout, err_misaligned, stall_cnt);
      end
   endtask

   task automatic test_misaligned();
      @(negedge clk);
      M_we_rf = 1'b1; M_sel_result = 2'b01; M_alu_o = 32'h203;
      #1;
      checks++;
      if (stall !== 1'b0 || mem_req_valid !== 1'b0) begin
         errors++;
         $display("FAIL misaligned_stall got stall=%b valid=%b exp 0 0", stall, mem_req_valid);
      end
      @(negedge clk);
      drive_nop();
      #1;
      checks++;
      if (err_misaligned !== 1'b1 || mem_req_valid !== 1'b0 || M_rd_data !== 32'hDEADBEEF ||
          stall_cnt !== 32'd30) begin
         errors++;
         $display("FAIL misaligned_flag got em=%b valid=%b rd=%h sc=%0d exp 1 0 deadbeef 30",
                  err_misaligned, mem_req_valid, M_rd_data, stall_cnt);
      end
   endtask

   task automatic test_idle_ignore();
      @(negedge clk);
      M_we_rf = 1'b1; M_sel_result = 2'b00; M_alu_o = 32'h300;
      mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'hAAAA5555; mem_req_ready = 1'b1;
      #1;
      checks++;
      if (stall !== 1'b0) begin
         errors++;
         $display("FAIL nonaccess_stall got %b exp 0", stall);
      end
      @(negedge clk);
      drive_nop();
      mem_rsp_valid = 1'b0; mem_req_ready = 1'b0;
      #1;
      checks++;
      if (M_rd_data !== 32'hDEADBEEF || mem_req_valid !== 1'b0 || stall !== 1'b0) begin
         errors++;
         $display("FAIL idle_ignore got rd=%h valid=%b stall=%b exp deadbeef 0 0",
                  M_rd_data, mem_req_valid, stall);
      end
   endtask

   task automatic test_back_to_back();
      int ns, nr;
      run_access(1'b1, 1'b1, 2'b01, 32'h40, 32'h11223344, 0, -1, 32'h0, 1'b1, ns, nr);
      checks++;
      if (ns != 2 || nr != 1 || stall_cnt !== 32'd32) begin
         errors++;
         $display("FAIL both_is_store got stall=%0d req=%0d sc=%0d exp 2 1 32", ns, nr, stall_cnt);
      end
      run_access(1'b0, 1'b1, 2'b01, 32'h44, 32'h0, 0, 2, 32'h0BADF00D, 1'b0, ns, nr);
      checks++;
      if (ns != 5 || M_rd_data !== 32'h0BADF00D || stall_cnt !== 32'd37) begin
         errors++;
         $display("FAIL b2b_load got stall=%0d rd=%h sc=%0d exp 5 0badf00d 37", ns, M_rd_data, stall_cnt);
      end
      checks++;
      if (err_misaligned !== 1'b1 || err_timeout !== 1'b1) begin
         errors++;
         $display("FAIL sticky_errs got em=%b et=%b exp 1 1", err_misaligned, err_timeout);
      end
   endtask

   task automatic test_reset_mid();
      int ns, nr;
      @(negedge clk);
      M_we_rf = 1'b1; M_sel_result = 2'b01; M_alu_o = 32'h300;
      @(negedge clk);
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      #1;
      checks++;
      if (stall !== 1'b1 || mem_req_valid !== 1'b0) begin
         errors++;
         $display("FAIL wait_rsp_entry got stall=%b valid=%b exp 1 0", stall, mem_req_valid);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (stall !== 1'b0 || mem_req_valid !== 1'b0 || mem_req_addr !== 32'h0 ||
          M_rd_data !== 32'h0 || err_misaligned !== 1'b0 || err_timeout !== 1'b0 ||
          stall_cnt !== 32'h0) begin
         errors++;
         $display("FAIL reset_mid got stall=%b v=%b a=%h rd=%h em=%b et=%b sc=%0d exp all zero",
                  stall, mem_req_valid, mem_req_addr, M_rd_data, err_misaligned, err_timeout, stall_cnt);
      end
      @(negedge clk);
      drive_nop();
      rst_n = 1'b1;
      @(negedge clk);
      mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h55AA55AA;
      #1;
      checks++;
      if (stall !== 1'b0) begin
         errors++;
         $display("FAIL late_rsp_stall got %b exp 0", stall);
      end
      @(negedge clk);
      mem_rsp_valid = 1'b0;
      #1;
      checks++;
      if (M_rd_data !== 32'h0 || mem_req_valid !== 1'b0 || stall_cnt !== 32'h0) begin
         errors++;
         $display("FAIL late_rsp_ignored got rd=%h valid=%b sc=%0d exp 0 0 0", M_rd_data, mem_req_valid, stall_cnt);
      end
      run_access(1'b1, 1'b0, 2'b00, 32'h80, 32'h87654321, 0, -1, 32'h0, 1'b1, ns, nr);
      checks++;
      if (ns != 2 || stall_cnt !== 32'd2) begin
         errors++;
         $display("FAIL post_reset_idle got stall=%0d sc=%0d exp 2 2", ns, stall_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_store();
      test_load();
      test_store_wait();
      test_timeout();
      test_misaligned();
      test_idle_ignore();
      test_back_to_back();
      test_reset_mid();
      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
